// File: rtl/ring_fifo_pkg.sv
// Shared types and helpers for the parametrised ring FIFO.
package ring_fifo_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Pointer width for a ring of the given depth; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (clog2(depth) > 0) ? clog2(depth) : 1;
    endfunction

    // Registered status bundle exposed by the FIFO.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/ring_fifo_mem.sv
// Simple dual-port storage array: one synchronous write port and one
// combinational read port. Contents are never reset.
module ring_fifo_mem
    import ring_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned ADDR_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  write_data,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [WIDTH-1:0]  read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store the word at the write address when enabled.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    // Read port is purely combinational from the address.
    assign read_data = mem[read_addr];

endmodule

// File: rtl/ring_fifo_param.sv
// Parametrised synchronous FIFO on a circular buffer with occupancy count,
// programmable almost-full/almost-empty flags and sticky error flags.
// Optional feature macro: RING_FIFO_FWFT_EN selects first-word-fall-through
// reads; when undefined, reads are registered with one cycle of latency.
module ring_fifo_param
    import ring_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_en,
    input  logic [WIDTH-1:0]         write_data,
    input  logic                     read_en,
    output logic [WIDTH-1:0]         read_data,
    output logic                     read_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Status value loaded by reset: empty FIFO, no errors.
    localparam fifo_status_t STATUS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  (AF_THRESH == 0),
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    fifo_status_t     status_q;
    fifo_status_t     status_d;
    logic             rd_acc;
    logic             wr_acc;
    logic             ovf_set;
    logic             udf_set;
    logic [WIDTH-1:0] mem_rdata;

    ring_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk        (clk),
        .write_en   (wr_acc && !rst),
        .write_addr (w_ptr),
        .write_data (write_data),
        .read_addr  (r_ptr),
        .read_data  (mem_rdata)
    );

    // Acceptance, next occupancy and the next status bundle.
    always_comb begin
        rd_acc     = read_en && !status_q.empty;
        wr_acc     = write_en && (!status_q.full || rd_acc);
        ovf_set    = write_en && !wr_acc;
        udf_set    = read_en && !rd_acc;
        count_next = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);

        status_d              = status_q;
        status_d.full         = (count_next == CNT_W'(DEPTH));
        status_d.empty        = (count_next == '0);
        status_d.almost_full  = (32'(count_next) >= AF_THRESH);
        status_d.almost_empty = (32'(count_next) <= AE_THRESH);
        // A set in the same cycle as a clear wins.
        status_d.overflow     = ovf_set || (status_q.overflow && !err_clr);
        status_d.underflow    = udf_set || (status_q.underflow && !err_clr);
    end

    // Pointers, occupancy and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            count_q  <= '0;
            status_q <= STATUS_RST;
        end else begin
            if (wr_acc) begin
                w_ptr <= w_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + PTR_W'(1);
            end
            count_q  <= count_next;
            status_q <= status_d;
        end
    end

`ifdef RING_FIFO_FWFT_EN
    // Head of the ring is always on display; read_en acknowledges it.
    assign read_data  = mem_rdata;
    assign read_valid = !status_q.empty;
`else
    logic [WIDTH-1:0] read_data_q;
    logic             read_valid_q;

    // Registered read: capture the head word on an accepted pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            read_valid_q <= rd_acc;
            if (rd_acc) begin
                read_data_q <= mem_rdata;
            end
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
`endif

    assign count        = count_q;
    assign full         = status_q.full;
    assign empty        = status_q.empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;
    assign overflow     = status_q.overflow;
    assign underflow    = status_q.underflow;

endmodule

// File: tb/tb_ring_fifo_param.sv
// Self-checking bench for ring_fifo_param (DEPTH=4, WIDTH=8, AF=3, AE=1).
// A queue-based model is compared against the DUT on every falling edge;
// directed steps add literal expectations. Honors RING_FIFO_FWFT_EN.
module tb_ring_fifo_param;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             write_en;
    logic [WIDTH-1:0] write_data;
    logic             read_en;
    logic             err_clr;
    logic [WIDTH-1:0] read_data;
    logic             read_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [2:0]       count;
    logic             overflow;
    logic             underflow;

    int n_checks;
    int n_fail;

    ring_fifo_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (3),
        .AE_THRESH (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_en     (write_en),
        .write_data   (write_data),
        .read_en      (read_en),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue plus sticky flags and the last popped word.
    logic [WIDTH-1:0] q[$];
    bit               m_ovf;
    bit               m_udf;
    bit               m_rv;
    logic [WIDTH-1:0] m_rd;
    bit               started;
    bit               m_rd_ok;
    bit               m_wr_ok;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_rv    = 1'b0;
            m_rd    = '0;
            started = 1'b1;
        end else begin
            m_rd_ok = read_en && (q.size() != 0);
            m_wr_ok = write_en && ((q.size() < DEPTH) || m_rd_ok);
            m_rv    = m_rd_ok;
            if (m_rd_ok) m_rd = q.pop_front();
            if (m_wr_ok) q.push_back(write_data);
            if (write_en && !m_wr_ok) m_ovf = 1'b1;
            else if (err_clr)         m_ovf = 1'b0;
            if (read_en && !m_rd_ok)  m_udf = 1'b1;
            else if (err_clr)         m_udf = 1'b0;
        end
    end

    // Continuous compare of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("count", int'(count), q.size());
            chk("full", int'(full), int'(q.size() == DEPTH));
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("almost_full", int'(almost_full), int'(q.size() >= 3));
            chk("almost_empty", int'(almost_empty), int'(q.size() <= 1));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("underflow", int'(underflow), int'(m_udf));
`ifdef RING_FIFO_FWFT_EN
            chk("read_valid", int'(read_valid), int'(q.size() != 0));
            if (q.size() != 0) chk("read_data", int'(read_data), int'(q[0]));
`else
            chk("read_valid", int'(read_valid), int'(m_rv));
            chk("read_data", int'(read_data), int'(m_rd));
`endif
        end
    end

    // One clock of stimulus; returns just after the following falling edge.
    task automatic step(input bit we, input logic [WIDTH-1:0] wd, input bit re,
                        input bit clr, input bit rs);
        write_en   = we;
        write_data = wd;
        read_en    = re;
        err_clr    = clr;
        rst        = rs;
        @(posedge clk);
        @(negedge clk);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        err_clr  = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clr_err();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    // Pop one word and check it against a hand-computed value.
    task automatic pop_expect(input string name, input int exp);
`ifdef RING_FIFO_FWFT_EN
        chk(name, int'(read_data), exp);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`else
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk(name, int'(read_data), exp);
        chk({name, "_valid"}, int'(read_valid), 1);
`endif
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        write_en   = 1'b0;
        write_data = '0;
        read_en    = 1'b0;
        err_clr    = 1'b0;

        // Reset state.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_ae", int'(almost_empty), 1);
        chk("rst_af", int'(almost_full), 0);
        chk("rst_rv", int'(read_valid), 0);
`ifndef RING_FIFO_FWFT_EN
        chk("rst_rd", int'(read_data), 0);
`endif

        // Fill to full, watching the flag thresholds.
        wr(8'h11); chk("fill1_count", int'(count), 1); chk("fill1_ae", int'(almost_empty), 1);
        wr(8'h22); chk("fill2_count", int'(count), 2); chk("fill2_ae", int'(almost_empty), 0);
        wr(8'h33); chk("fill3_count", int'(count), 3); chk("fill3_af", int'(almost_full), 1);
        chk("fill3_full", int'(full), 0);
        wr(8'h44); chk("fill4_count", int'(count), 4); chk("fill4_full", int'(full), 1);
        chk("fill4_ovf", int'(overflow), 0);

        // Write into full with no read is rejected.
        wr(8'h55);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 4);
        clr_err();
        chk("ovf_clr", int'(overflow), 0);
        pop_expect("pop_11", 8'h11);
        pop_expect("pop_22", 8'h22);
        pop_expect("pop_33", 8'h33);
        pop_expect("pop_44", 8'h44);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("udf_set", int'(underflow), 1);
        chk("udf_rv", int'(read_valid), 0);
        clr_err();

        // Simultaneous write and read on a full FIFO.
        wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4);
`ifdef RING_FIFO_FWFT_EN
        chk("full_rw_rd", int'(read_data), 8'hA1);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
`else
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        chk("full_rw_rd", int'(read_data), 8'hA1);
`endif
        chk("full_rw_count", int'(count), 4);
        chk("full_rw_full", int'(full), 1);
        chk("full_rw_ovf", int'(overflow), 0);
        pop_expect("pop_a2", 8'hA2);
        pop_expect("pop_a3", 8'hA3);
        pop_expect("pop_a4", 8'hA4);
        pop_expect("pop_aa", 8'hAA);

        // Ten push/pop pairs at count 2: pointers wrap more than twice.
        wr(8'hE0); wr(8'hE1);
        for (int i = 0; i < 10; i++) begin
            int exp;
            exp = (i < 2) ? (8'hE0 + i) : (i - 2);
`ifdef RING_FIFO_FWFT_EN
            chk("pair_rd", int'(read_data), exp);
            step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
`else
            step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
            chk("pair_rd", int'(read_data), exp);
`endif
            chk("pair_count", int'(count), 2);
        end
        pop_expect("pair_tail8", 8);
        pop_expect("pair_tail9", 9);

        // Reset mid-burst with write_en still high.
        wr(8'h01); wr(8'h02); wr(8'h03);
        step(1'b1, 8'h04, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_rv", int'(read_valid), 0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("mid_rst_udf", int'(underflow), 1);
        clr_err();

        // Write into empty with a same-cycle read: write lands, read rejected.
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("empty_rw_count", int'(count), 1);
        chk("empty_rw_udf", int'(underflow), 1);
        clr_err();
        pop_expect("pop_77", 8'h77);

        // A new error in the same cycle as err_clr stays set.
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("clr_vs_set", int'(underflow), 1);
        clr_err();
        chk("clr_after", int'(underflow), 0);

`ifdef RING_FIFO_FWFT_EN
        // Fall-through: word shows without read_en, pop empties the FIFO.
        wr(8'h5A);
        chk("fwft_rv", int'(read_valid), 1);
        chk("fwft_rd", int'(read_data), 8'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("fwft_empty", int'(empty), 1);
        chk("fwft_rv_off", int'(read_valid), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
